sha3_digest_serializer: RTL and testbench



---
 rtl/sha3_pkg.sv | 38 +++
 rtl/sha3_digest_serializer_if.sv | 14 +
 rtl/sha3_digest_serializer.sv | 81 ++++++++
 tb/tb_sha3_digest_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA-3 round pipeline and its digest output stage.
package sha3_pkg;

   localparam int LANE_W = 64;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Iota round constants, indexed by round number.
   localparam logic [LANE_W-1:0] RC [24] = '{
      64'h0000_0000_0000_0001, 64'h0000_0000_0000_8082,
      64'h8000_0000_0000_808A, 64'h8000_0000_8000_8000,
      64'h0000_0000_0000_808B, 64'h0000_0000_8000_0001,
      64'h8000_0000_8000_8081, 64'h8000_0000_0000_8009,
      64'h0000_0000_0000_008A, 64'h0000_0000_0000_0088,
      64'h0000_0000_8000_8009, 64'h0000_0000_8000_000A,
      64'h0000_0000_8000_808B, 64'h8000_0000_0000_008B,
      64'h8000_0000_0000_8089, 64'h8000_0000_0000_8003,
      64'h8000_0000_0000_8002, 64'h8000_0000_0000_0080,
      64'h0000_0000_0000_800A, 64'h8000_0000_8000_000A,
      64'h8000_0000_8000_8081, 64'h8000_0000_0000_8080,
      64'h0000_0000_8000_0001, 64'h8000_0000_8000_8008
   };

   function automatic int digest_words(input int bits);
      return (bits + LANE_W - 1) / LANE_W;
   endfunction

   // Byte mask of the final word; a partial word keeps only its low bytes.
   function automatic logic [7:0] last_keep(input int bits);
      int rem_bytes;
      rem_bytes = (bits % LANE_W) / 8;
      return (rem_bytes == 0) ? 8'hFF : 8'((1 << rem_bytes) - 1);
   endfunction

endpackage

// File: rtl/sha3_digest_serializer_if.sv
// Digest word stream: valid/ready handshake with byte keep and end-of-digest flag.
interface sha3_digest_serializer_if;
   import sha3_pkg::*;

   logic [LANE_W-1:0] odata;
   logic [7:0]        okeep;
   logic              ovalid;
   logic              olast;
   logic              iready;

   modport master (output odata, okeep, ovalid, olast, input iready);
   modport slave  (input odata, okeep, ovalid, olast, output iready);

endinterface

// File: rtl/sha3_digest_serializer.sv
// Captures the final Keccak state on sample and streams the digest lanes
// one 64-bit word per beat, accepting a new state on the final handshake.
module sha3_digest_serializer
   import sha3_pkg::*;
#(
   parameter int DIGEST_BITS = 256
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [4:0][LANE_W-1:0]   isa,
   input  logic [4:0][LANE_W-1:0]   isb,
   input  logic [4:0][LANE_W-1:0]   isc,
   input  logic [4:0][LANE_W-1:0]   isd,
   input  logic [4:0][LANE_W-1:0]   ise,
   input  logic                     sample,
   output logic                     ocan_sample,
   output logic                     ooverflow,
   sha3_digest_serializer_if.master dbus
);

   localparam int              WORDS     = digest_words(DIGEST_BITS);
   localparam int              CW        = $clog2(WORDS);
   localparam logic [7:0]      LAST_KEEP = last_keep(DIGEST_BITS);
   localparam logic [CW-1:0]   LAST_IDX  = CW'(WORDS - 1);

   if (!(DIGEST_BITS == 224 || DIGEST_BITS == 256 ||
         DIGEST_BITS == 384 || DIGEST_BITS == 512)) begin : g_bad_bits
      $error("sha3_digest_serializer: illegal DIGEST_BITS %0d", DIGEST_BITS);
   end

   logic [24:0][LANE_W-1:0]    lanes;
   logic [WORDS-1:0][LANE_W-1:0] cap;
   state_e                     state;
   logic [CW-1:0]              cnt;
   logic                       is_last;
   logic                       take;
   logic                       unused_lanes;
   logic [7:0]                 keep;
   logic [LANE_W-1:0]          mask;

   // Lane index i = x + 5y, so row A sits in the low lanes.
   assign lanes        = {ise, isd, isc, isb, isa};
   assign unused_lanes = ^lanes;

   assign is_last     = (cnt == LAST_IDX);
   assign ocan_sample = (state == IDLE) ||
                        ((state == SEND) && is_last && dbus.iready);
   assign take        = sample && ocan_sample;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         cap       <= '0;
         ooverflow <= 1'b0;
      end else begin
         ooverflow <= sample && !ocan_sample;
         if (take) begin
            // Also covers a sample on the final handshake: restart with no bubble.
            cap   <= lanes[WORDS-1:0];
            cnt   <= '0;
            state <= SEND;
         end else if ((state == SEND) && dbus.iready) begin
            if (is_last) state <= IDLE;
            else         cnt   <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      keep = '0;
      if (state == SEND) keep = is_last ? LAST_KEEP : 8'hFF;
      for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{keep[b]}};
   end

   assign dbus.ovalid = (state == SEND);
   assign dbus.olast  = (state == SEND) && is_last;
   assign dbus.okeep  = keep;
   assign dbus.odata  = cap[cnt] & mask;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Four serializer instances (256/224/512/384) exercised in turn; a monitor
// scores every accepted beat against an expected-beat queue.
module tb_sha3_digest_serializer;
   import sha3_pkg::*;

   localparam int NI = 4;
   localparam int BITS [NI] = '{256, 224, 512, 384};
   localparam int WRDS [NI] = '{4, 4, 8, 6};

   typedef struct {
      int          k;
      logic [63:0] d;
      logic [7:0]  kp;
      logic        l;
   } beat_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic [63:0]        lanes [25];
   logic [4:0][63:0]   isa, isb, isc, isd, ise;
   logic [NI-1:0]      samp, rdy, vld, lst, can, ovf;
   logic [NI-1:0][63:0] dat;
   logic [NI-1:0][7:0]  kp;

   beat_t exp_q [$];
   int    checks = 0;
   int    errors = 0;
   int    ovf_cnt [NI] = '{default: 0};

   always_comb begin
      for (int x = 0; x < 5; x++) begin
         isa[x] = lanes[x];
         isb[x] = lanes[5 + x];
         isc[x] = lanes[10 + x];
         isd[x] = lanes[15 + x];
         ise[x] = lanes[20 + x];
      end
   end

   for (genvar k = 0; k < NI; k++) begin : g_dut
      sha3_digest_serializer_if bus ();
      assign bus.iready = rdy[k];
      assign vld[k] = bus.ovalid;
      assign lst[k] = bus.olast;
      assign dat[k] = bus.odata;
      assign kp[k]  = bus.okeep;
      sha3_digest_serializer #(.DIGEST_BITS(BITS[k])) u_dut (
         .clk         (clk),
         .rstn        (rstn),
         .isa         (isa),
         .isb         (isb),
         .isc         (isc),
         .isd         (isd),
         .ise         (ise),
         .sample      (samp[k]),
         .ocan_sample (can[k]),
         .ooverflow   (ovf[k]),
         .dbus        (bus)
      );
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_lanes(input logic [63:0] base);
      for (int i = 0; i < 25; i++) lanes[i] = base * 64'(i + 1);
   endtask

   // Expected beats for instance k from the lanes currently driven.
   task automatic push_digest(input int k);
      beat_t b;
      for (int j = 0; j < WRDS[k]; j++) begin
         b.k  = k;
         b.d  = lanes[j];
         b.l  = (j == WRDS[k] - 1);
         b.kp = 8'hFF;
         if (b.l && BITS[k] == 224) begin
            b.d[63:32] = 32'h0;
            b.kp       = 8'h0F;
         end
         exp_q.push_back(b);
      end
   endtask

   // Runs from just after a posedge until the final beat is accepted.
   task automatic run_stream(input int k, input bit toggle, output int cyc, output int stalls);
      bit done = 0;
      cyc = 0;
      stalls = 0;
      for (int n = 0; n < 200 && !done; n++) begin
         if (toggle) rdy[k] = (cyc % 4 == 0) || (cyc % 4 == 3);
         @(negedge clk);
         cyc++;
         if (vld[k] && !rdy[k]) stalls++;
         if (vld[k] && rdy[k] && lst[k]) done = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("stream_done", 64'(done), 64'd1);
   endtask

   task automatic issue(input int k);
      push_digest(k);
      samp[k] = 1'b1;
      @(posedge clk);
      #1;
      samp[k] = 1'b0;
   endtask

   // Scoreboard monitor: accepted beats, stall stability, overflow pulses.
   initial begin
      logic [NI-1:0]       pv, pr, pl;
      logic [NI-1:0][63:0] pd;
      logic [NI-1:0][7:0]  pk;
      beat_t e;
      pv = '0; pr = '0; pl = '0; pd = '0; pk = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (!rstn) pv[k] = 1'b0;
            else begin
               if (ovf[k]) ovf_cnt[k]++;
               if (pv[k] && !pr[k]) begin
                  chk("stall_valid", 64'(vld[k]), 64'd1);
                  chk("stall_data",  dat[k], pd[k]);
                  chk("stall_keep",  64'(kp[k]), 64'(pk[k]));
                  chk("stall_last",  64'(lst[k]), 64'(pl[k]));
               end
               if (vld[k] && rdy[k]) begin
                  if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                  else begin
                     e = exp_q.pop_front();
                     chk("beat_inst", 64'(k), 64'(e.k));
                     chk("beat_data", dat[k], e.d);
                     chk("beat_keep", 64'(kp[k]), 64'(e.kp));
                     chk("beat_last", 64'(lst[k]), 64'(e.l));
                  end
               end
               pv[k] = vld[k]; pr[k] = rdy[k]; pd[k] = dat[k];
               pk[k] = kp[k];  pl[k] = lst[k];
            end
         end
      end
   end

   initial begin
      int c, s;
      samp = '0;
      rdy  = '0;
      set_lanes(64'h0101_0101_0101_0101);
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("rst_valid", 64'(vld[k]), 64'd0);
         chk("rst_last",  64'(lst[k]), 64'd0);
         chk("rst_data",  dat[k], 64'd0);
         chk("rst_keep",  64'(kp[k]), 64'd0);
         chk("rst_ovf",   64'(ovf[k]), 64'd0);
         chk("rst_can",   64'(can[k]), 64'd1);
      end
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // 256 and 224 bits, iready held high.
      for (int k = 0; k < 2; k++) begin
         rdy[k] = 1'b1;
         issue(k);
         chk("mid_can", 64'(can[k]), 64'd0);
         run_stream(k, 0, c, s);
         chk("cycles_full_rate", 64'(c), 64'd4);
         @(posedge clk);
         #1;
         chk("idle_valid", 64'(vld[k]), 64'd0);
         chk("idle_can",   64'(can[k]), 64'd1);
         rdy[k] = 1'b0;
      end

      // 512 bits with iready pattern 1,0,0,1.
      set_lanes(64'h0123_4567_89AB_CDEF);
      issue(2);
      run_stream(2, 1, c, s);
      chk("stall_count", 64'(s), 64'd8);
      chk("cycles_with_stalls", 64'(c), 64'(8 + s));
      @(posedge clk);
      #1;
      rdy[2] = 1'b0;

      // 384 bits, second sample on the final accepted beat.
      rdy[3] = 1'b1;
      set_lanes(64'h0202_0202_0202_0202);
      issue(3);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("b2b_valid", 64'(vld[3]), 64'd1);
         @(posedge clk);
         #1;
      end
      set_lanes(64'h1000_0000_0000_0001);
      #1;
      chk("b2b_can_last", 64'(can[3]), 64'd1);
      issue(3);
      chk("b2b_no_bubble", 64'(vld[3]), 64'd1);
      run_stream(3, 0, c, s);
      chk("b2b_cycles", 64'(c), 64'd6);
      chk("b2b_no_ovf", 64'(ovf_cnt[3]), 64'd0);
      @(posedge clk);
      #1;
      rdy[3] = 1'b0;

      // Overflow: sample during stalled beat 1.
      set_lanes(64'h0101_0101_0101_0101);
      rdy[0] = 1'b1;
      issue(0);
      @(posedge clk);
      #1;
      rdy[0] = 1'b0;
      set_lanes(64'hA5A5_A5A5_A5A5_A5A5);
      samp[0] = 1'b1;
      #1;
      chk("ovf_can", 64'(can[0]), 64'd0);
      @(posedge clk);
      #1;
      samp[0] = 1'b0;
      chk("ovf_pulse", 64'(ovf[0]), 64'd1);
      @(posedge clk);
      #1;
      chk("ovf_one_cycle", 64'(ovf[0]), 64'd0);
      rdy[0] = 1'b1;
      run_stream(0, 0, c, s);
      chk("ovf_rest_cycles", 64'(c), 64'd3);
      @(posedge clk);
      #1;
      chk("ovf_then_idle", 64'(vld[0]), 64'd0);
      chk("ovf_count", 64'(ovf_cnt[0]), 64'd1);

      // Reset during beat 2, then a fresh digest from word 0.
      set_lanes(64'h0F0F_0000_F0F0_0001);
      issue(0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rstn = 1'b0;
      #1;
      chk("mrst_valid", 64'(vld[0]), 64'd0);
      chk("mrst_data",  dat[0], 64'd0);
      chk("mrst_keep",  64'(kp[0]), 64'd0);
      chk("mrst_last",  64'(lst[0]), 64'd0);
      chk("mrst_ovf",   64'(ovf[0]), 64'd0);
      chk("mrst_can",   64'(can[0]), 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      set_lanes(64'h3333_0000_0000_0007);
      issue(0);
      run_stream(0, 0, c, s);
      chk("post_rst_cycles", 64'(c), 64'd4);
      @(posedge clk);
      #1;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
